// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the fetch stage.
package fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DISCARD
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] INSTR_BYTES = 32'd4;

endpackage

// File: rtl/fetch_sequencer_buffer.sv
// Fetch FIFO: holds {pc, instr} pairs between instruction memory and decode.
// A pop frees its slot before a same-cycle push; flush overrides push and pop.
module fetch_buffer
  import fetch_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  fetch_entry_t               push_data,
  input  logic                       pop,
  input  logic                       flush,
  output fetch_entry_t               head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  fetch_entry_t    mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic            do_push;
  logic            do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents only matter while counted as occupied.
  always_ff @(posedge clk) begin
    if (reset && !flush && do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch stage sequencer: owns the PC, issues one instruction-memory request
// at a time and queues returned {pc, instr} pairs for decode.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_enable,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_instr,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr
);

  localparam int unsigned CW = $clog2(BUF_DEPTH) + 1;

  fetch_state_t  state;
  fetch_state_t  state_next;
  logic [31:0]   pc;
  logic [31:0]   pc_next;
  logic [31:0]   redirect_aligned;
  logic          outstanding;
  logic          outstanding_next;
  logic          push;
  logic          pop;
  logic          space;
  logic [CW:0]   occupancy;
  logic [CW-1:0] buf_count;
  logic          buf_full;
  logic          buf_empty;
  fetch_entry_t  push_entry;
  fetch_entry_t  head;

  assign redirect_aligned = redirect_pc & ~32'h3;
  assign occupancy        = {1'b0, buf_count} + {{CW{1'b0}}, outstanding};
  assign space            = (occupancy < (CW+1)'(BUF_DEPTH));
  assign pop              = ~buf_empty & if_ready;
  assign push_entry       = '{pc: pc, instr: imem_resp_instr};

  assign imem_req_valid = (state == REQ);
  assign imem_req_addr  = {pc[31:2], 2'b00};
  assign if_valid       = ~buf_empty;
  assign if_pc          = head.pc;
  assign if_instr       = head.instr;

  fetch_buffer #(
    .DEPTH (BUF_DEPTH)
  ) u_buffer (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect_valid),
    .head      (head),
    .count     (buf_count),
    .full      (buf_full),
    .empty     (buf_empty)
  );

  // State, PC and outstanding-request registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      outstanding <= 1'b0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      outstanding <= outstanding_next;
    end
  end

  // Next-state, PC update and FIFO push; redirect wins in every state.
  always_comb begin
    state_next       = state;
    pc_next          = pc;
    outstanding_next = outstanding;
    push             = 1'b0;
    case (state)
      IDLE: begin
        if (redirect_valid) begin
          pc_next = redirect_aligned;
        end else if (fetch_enable && space) begin
          state_next = REQ;
        end
      end
      REQ: begin
        if (imem_req_ready) begin
          outstanding_next = 1'b1;
        end
        if (redirect_valid) begin
          pc_next = redirect_aligned;
          if (imem_req_ready) state_next = DISCARD;
        end else if (imem_req_ready) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          pc_next = redirect_aligned;
          if (imem_resp_valid) begin
            outstanding_next = 1'b0;
            state_next       = REQ;
          end else begin
            state_next = DISCARD;
          end
        end else if (imem_resp_valid) begin
          push             = 1'b1;
          outstanding_next = 1'b0;
          pc_next          = pc + INSTR_BYTES;
          // space still counts the outstanding slot, which equals the
          // occupancy after this push lands.
          state_next       = (fetch_enable && space) ? REQ : IDLE;
        end
      end
      DISCARD: begin
        if (redirect_valid) begin
          pc_next = redirect_aligned;
        end
        // A response coinciding with a further redirect still retires the
        // stale request, otherwise nothing would ever leave DISCARD.
        if (imem_resp_valid) begin
          outstanding_next = 1'b0;
          state_next       = fetch_enable ? REQ : IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Space accounting guarantees the FIFO never overflows.
  no_overflow: assert property (@(posedge clk) disable iff (!reset)
    (push && !redirect_valid) |-> (!buf_full || pop));

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a simple instruction-memory
// responder (instr = ~addr) and a decode-side pop recorder.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_enable;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_instr;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  int n_tests = 0;
  int n_fail  = 0;
  int lat     = 1;

  logic [31:0] issued[$];
  logic [31:0] pop_pc[$];
  logic [31:0] pop_instr[$];

  logic        pend;
  int          cnt;
  logic [31:0] paddr;

  always #5 clk = ~clk;

  fetch_sequencer #(
    .RESET_PC  (32'h0000_0000),
    .BUF_DEPTH (2)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .fetch_enable    (fetch_enable),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_instr (imem_resp_instr),
    .if_valid        (if_valid),
    .if_ready        (if_ready),
    .if_pc           (if_pc),
    .if_instr        (if_instr)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ~a;
  endfunction

  function automatic logic [31:0] qat(input logic [31:0] q[$], input int k);
    if (k < q.size()) return q[k];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic restart();
    fetch_enable = 1'b0;
    repeat (8) tick();
    reset = 1'b0;
    repeat (2) tick();
    issued.delete();
    pop_pc.delete();
    pop_instr.delete();
  endtask

  // Memory responder: one response lat cycles after each accepted request.
  initial begin
    pend            = 1'b0;
    cnt             = 0;
    paddr           = '0;
    imem_resp_valid = 1'b0;
    imem_resp_instr = '0;
    forever begin
      @(negedge clk);
      imem_resp_valid = 1'b0;
      if (pend) begin
        if (cnt <= 1) begin
          imem_resp_valid = 1'b1;
          imem_resp_instr = mem_word(paddr);
          pend            = 1'b0;
        end else begin
          cnt--;
        end
      end
      if (imem_req_valid && imem_req_ready) begin
        pend  = 1'b1;
        cnt   = lat;
        paddr = imem_req_addr;
        issued.push_back(imem_req_addr);
      end
    end
  end

  // Decode-side recorder: logs each head that will be accepted at the next edge.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (if_valid && if_ready && reset) begin
        pop_pc.push_back(if_pc);
        pop_instr.push_back(if_instr);
      end
    end
  end

  initial begin
    logic found;
    reset          = 1'b0;
    fetch_enable   = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b0;
    if_ready       = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_req_valid", imem_req_valid, 32'd0);
    check("rst_req_addr",  imem_req_addr,  32'h0);
    check("rst_if_valid",  if_valid,       32'd0);
    check("rst_if_pc",     if_pc,          32'h0);
    check("rst_if_instr",  if_instr,       32'h0);

    // 1: streaming fetch, 1-cycle memory
    restart();
    imem_req_ready = 1'b1; if_ready = 1'b1; lat = 1; fetch_enable = 1'b1; reset = 1'b1;
    check("t1_req_before", imem_req_valid, 32'd0);
    tick();
    check("t1_first_req_valid", imem_req_valid, 32'd1);
    check("t1_first_req_addr",  imem_req_addr,  32'h0);
    repeat (12) tick();
    for (int k = 0; k < 4; k++) begin
      check("t1_issue_addr", qat(issued, k),    32'(4 * k));
      check("t1_pop_pc",     qat(pop_pc, k),    32'(4 * k));
      check("t1_pop_instr",  qat(pop_instr, k), ~32'(4 * k));
    end

    // 2: decode stalled, FIFO fills then fetch resumes
    restart();
    imem_req_ready = 1'b1; if_ready = 1'b0; lat = 1; fetch_enable = 1'b1; reset = 1'b1;
    repeat (14) tick();
    check("t2_num_req",    32'(issued.size()), 32'd2);
    check("t2_req1_addr",  qat(issued, 1),     32'h4);
    check("t2_stalled",    imem_req_valid,     32'd0);
    check("t2_head_valid", if_valid,           32'd1);
    check("t2_head_pc",    if_pc,              32'h0);
    if_ready = 1'b1;
    repeat (10) tick();
    check("t2_resume_addr", qat(issued, 2), 32'h8);
    check("t2_pop0",        qat(pop_pc, 0), 32'h0);
    check("t2_pop1",        qat(pop_pc, 1), 32'h4);
    check("t2_pop2",        qat(pop_pc, 2), 32'h8);

    // 3: redirect while WAIT, stale response 3 cycles after accept
    restart();
    imem_req_ready = 1'b1; if_ready = 1'b1; lat = 3; fetch_enable = 1'b1; reset = 1'b1;
    tick();
    check("t3_req0_valid", imem_req_valid, 32'd1);
    lat = 1;
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect_valid = 1'b0;
    check("t3_discard_if_valid", if_valid,       32'd0);
    check("t3_discard_no_req",   imem_req_valid, 32'd0);
    tick();
    tick();
    check("t3_drop_if_valid", if_valid,       32'd0);
    check("t3_req_valid",     imem_req_valid, 32'd1);
    check("t3_req_addr",      imem_req_addr,  32'h100);
    repeat (6) tick();
    check("t3_pop_pc",    qat(pop_pc, 0),    32'h100);
    check("t3_pop_instr", qat(pop_instr, 0), 32'hFFFF_FEFF);

    // 4: unaligned redirect coinciding with a response, FIFO non-empty
    restart();
    imem_req_ready = 1'b1; if_ready = 1'b0; lat = 1; fetch_enable = 1'b1; reset = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (imem_resp_valid && issued.size() == 2) found = 1'b1;
    end
    check("t4_sync",         found,    32'd1);
    check("t4_pre_if_valid", if_valid, 32'd1);
    redirect_valid = 1'b1; redirect_pc = 32'h203;
    tick();
    redirect_valid = 1'b0;
    check("t4_flushed",  if_valid,       32'd0);
    check("t4_req_valid", imem_req_valid, 32'd1);
    check("t4_req_addr", imem_req_addr,  32'h200);
    if_ready = 1'b1;
    repeat (6) tick();
    check("t4_pop_pc",    qat(pop_pc, 0),    32'h200);
    check("t4_pop_instr", qat(pop_instr, 0), 32'hFFFF_FDFF);

    // 5: PC wraps past the top of the address space
    restart();
    imem_req_ready = 1'b1; if_ready = 1'b1; lat = 1; fetch_enable = 1'b0; reset = 1'b1;
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0; fetch_enable = 1'b1;
    check("t5_idle_no_req", imem_req_valid, 32'd0);
    repeat (10) tick();
    check("t5_req0",       qat(issued, 0),    32'hFFFF_FFFC);
    check("t5_req1",       qat(issued, 1),    32'h0);
    check("t5_pop0_pc",    qat(pop_pc, 0),    32'hFFFF_FFFC);
    check("t5_pop0_instr", qat(pop_instr, 0), 32'h0000_0003);
    check("t5_pop1_pc",    qat(pop_pc, 1),    32'h0);

    // 6: reset during WAIT, stale response afterwards is ignored
    restart();
    imem_req_ready = 1'b1; if_ready = 1'b1; lat = 3; fetch_enable = 1'b1; reset = 1'b1;
    tick();
    check("t6_req0_valid", imem_req_valid, 32'd1);
    tick();
    reset = 1'b0; lat = 1;
    tick();
    check("t6_rst_req_valid", imem_req_valid, 32'd0);
    check("t6_rst_req_addr",  imem_req_addr,  32'h0);
    check("t6_rst_if_valid",  if_valid,       32'd0);
    reset = 1'b1;
    tick();
    check("t6_req_valid", imem_req_valid, 32'd1);
    check("t6_req_addr",  imem_req_addr,  32'h0);
    tick();
    check("t6_no_stale_push", if_valid, 32'd0);
    repeat (8) tick();
    check("t6_pop0_pc",    qat(pop_pc, 0),    32'h0);
    check("t6_pop1_pc",    qat(pop_pc, 1),    32'h4);
    check("t6_pop1_instr", qat(pop_instr, 1), 32'hFFFF_FFFB);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
